// File: rtl/nokia_frame_streamer.sv
// PCD8544 (Nokia 5110) frame streamer: LCD reset + init, then streams
// 84x48 frame-buffer columns as 504 bytes over the 3-wire+DC serial link.
//
// Ports:
//   clk, rst             system clock, synchronous active-high reset
//   start, ready         frame request (taken in IDLE) / idle indicator
//   frame_done           one-cycle pulse after the last data byte
//   bram_rd_en/addr      column read strobe and index 0..83
//   bram_data/valid      48-bit column word (bit 0 = top), valid strobe
//   lcd_*                PCD8544 pins (rst_n, ce_n, dc, sclk, din)
//
// Build option: NOKIA_AUTO_REFRESH_EN makes IDLE restart a frame on the
// next cycle without waiting for start.
module nokia_frame_streamer #(
  parameter int         CLK_DIV    = 4,
  parameter int         RST_CYCLES = 16,
  parameter logic [6:0] VOP        = 7'h31
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        ready,
  output logic        frame_done,
  output logic        bram_rd_en,
  output logic [6:0]  bram_rd_addr,
  input  logic [47:0] bram_data,
  input  logic        bram_valid,
  output logic        lcd_rst_n,
  output logic        lcd_ce_n,
  output logic        lcd_dc,
  output logic        lcd_sclk,
  output logic        lcd_din
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  typedef enum logic [3:0] {
    S_LCD_RST,
    S_LCD_WAIT,
    S_INIT,
    S_IDLE,
    S_HDR,
    S_FETCH,
    S_WAIT_VALID,
    S_SEND,
    S_DONE
  } state_t;

  state_t state, nxt;

  logic [RW-1:0] rst_cnt;
  logic [DW-1:0] div_cnt;
  logic [4:0]    phase;
  logic [2:0]    idx;
  logic [6:0]    col;
  logic [2:0]    bank;
  logic [7:0]    data_byte;
  logic [7:0]    init_byte;
  logic [7:0]    bank_byte;
  logic [7:0]    tx_byte;

  logic rst_done;
  logic tx_on;
  logic div_end;
  logic byte_done;
  logic shifting;
  logic last_col;
  logic last_bank;

  assign rst_done  = rst_cnt == RW'(RST_CYCLES - 1);
  assign tx_on     = state inside {S_INIT, S_HDR, S_SEND};
  assign div_end   = div_cnt == DW'(CLK_DIV - 1);
  // phase 0..15: low/high half-bits, phase 16: inter-byte gap
  assign byte_done = (phase == 5'd16) && div_end;
  assign shifting  = tx_on && !phase[4];
  assign last_col  = col == 7'd83;
  assign last_bank = bank == 3'd5;

`ifdef NOKIA_AUTO_REFRESH_EN
  logic unused_start;
  assign unused_start = start;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= S_LCD_RST;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      S_LCD_RST:  if (rst_done) nxt = S_LCD_WAIT;
      S_LCD_WAIT: if (rst_done) nxt = S_INIT;
      S_INIT:
        if (byte_done && idx == 3'd5) nxt = S_IDLE;
      S_IDLE: begin
`ifdef NOKIA_AUTO_REFRESH_EN
        nxt = S_HDR;
`else
        if (start) nxt = S_HDR;
`endif
      end
      S_HDR:
        if (byte_done && idx == 3'd1) nxt = S_FETCH;
      S_FETCH:      nxt = S_WAIT_VALID;
      S_WAIT_VALID: if (bram_valid) nxt = S_SEND;
      S_SEND:
        if (byte_done)
          nxt = (last_col && last_bank) ? S_DONE : S_FETCH;
      S_DONE:       nxt = S_IDLE;
      default:      nxt = S_LCD_RST;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rst_cnt   <= '0;
      div_cnt   <= '0;
      phase     <= '0;
      idx       <= '0;
      col       <= '0;
      bank      <= '0;
      data_byte <= '0;
    end else begin
      if ((state == S_LCD_RST || state == S_LCD_WAIT) && !rst_done)
        rst_cnt <= rst_cnt + RW'(1);
      else
        rst_cnt <= '0;

      if (!tx_on || byte_done) begin
        div_cnt <= '0;
        phase   <= '0;
      end else if (div_end) begin
        div_cnt <= '0;
        phase   <= phase + 5'd1;
      end else begin
        div_cnt <= div_cnt + DW'(1);
      end

      // command index shared by INIT and HDR, cleared on state exit
      if (!(state == S_INIT || state == S_HDR))
        idx <= '0;
      else if (byte_done)
        idx <= (nxt == state) ? idx + 3'd1 : 3'd0;

      if (state == S_IDLE) begin
        col  <= '0;
        bank <= '0;
      end else if (state == S_SEND && byte_done) begin
        if (last_col) begin
          col  <= '0;
          bank <= bank + 3'd1;
        end else begin
          col <= col + 7'd1;
        end
      end

      if (state == S_WAIT_VALID && bram_valid)
        data_byte <= bank_byte;
    end
  end

  always_comb begin
    init_byte = 8'h00;
    unique case (idx)
      3'd0:    init_byte = 8'h21;
      3'd1:    init_byte = {1'b1, VOP};
      3'd2:    init_byte = 8'h04;
      3'd3:    init_byte = 8'h14;
      3'd4:    init_byte = 8'h20;
      3'd5:    init_byte = 8'h0C;
      default: init_byte = 8'h00;
    endcase
  end

  always_comb begin
    bank_byte = 8'h00;
    unique case (bank)
      3'd0:    bank_byte = bram_data[7:0];
      3'd1:    bank_byte = bram_data[15:8];
      3'd2:    bank_byte = bram_data[23:16];
      3'd3:    bank_byte = bram_data[31:24];
      3'd4:    bank_byte = bram_data[39:32];
      3'd5:    bank_byte = bram_data[47:40];
      default: bank_byte = 8'h00;
    endcase
  end

  always_comb begin
    tx_byte = data_byte;
    unique case (1'b1)
      state == S_INIT: tx_byte = init_byte;
      state == S_HDR:  tx_byte = idx[0] ? 8'h80 : 8'h40;
      default:         tx_byte = data_byte;
    endcase
  end

  assign lcd_rst_n    = state != S_LCD_RST;
  assign lcd_ce_n     = !shifting;
  assign lcd_sclk     = shifting && phase[0];
  assign lcd_din      = shifting && tx_byte[3'd7 - phase[3:1]];
  assign lcd_dc       = state == S_SEND;
  assign ready        = state == S_IDLE;
  assign frame_done   = state == S_DONE;
  assign bram_rd_en   = state == S_FETCH;
  assign bram_rd_addr = col;

endmodule

// File: tb/tb_nokia_frame_streamer.sv
// Testbench for nokia_frame_streamer: decodes the serial link and
// compares it with a frame model built from a BRAM content array.
module tb_nokia_frame_streamer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        ready, frame_done, bram_rd_en;
  logic [6:0]  bram_rd_addr;
  logic [47:0] bram_data = '0;
  logic        bram_valid = 1'b0;
  logic        lcd_rst_n, lcd_ce_n, lcd_dc, lcd_sclk, lcd_din;

  nokia_frame_streamer dut (
    .clk(clk), .rst(rst), .start(start),
    .ready(ready), .frame_done(frame_done),
    .bram_rd_en(bram_rd_en), .bram_rd_addr(bram_rd_addr),
    .bram_data(bram_data), .bram_valid(bram_valid),
    .lcd_rst_n(lcd_rst_n), .lcd_ce_n(lcd_ce_n), .lcd_dc(lcd_dc),
    .lcd_sclk(lcd_sclk), .lcd_din(lcd_din)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  logic [47:0] mem [0:83];
  bit          rand_dly = 1'b0;

  // BRAM: data one cycle after rd_en, or later when rand_dly is set
  logic       b_pend = 1'b0;
  logic [6:0] b_pa = '0;
  int         b_cnt = 0;
  always @(posedge clk) begin
    int d;
    d = rand_dly ? int'($urandom_range(3, 0)) : 0;
    bram_valid <= 1'b0;
    bram_data  <= {16'($urandom), $urandom};
    if (bram_rd_en) begin
      if (d == 0) begin
        bram_valid <= 1'b1;
        bram_data  <= mem[bram_rd_addr];
      end else begin
        b_pend <= 1'b1;
        b_pa   <= bram_rd_addr;
        b_cnt  <= d;
      end
    end else if (b_pend) begin
      if (b_cnt == 1) begin
        bram_valid <= 1'b1;
        bram_data  <= mem[b_pa];
        b_pend     <= 1'b0;
      end else begin
        b_cnt <= b_cnt - 1;
      end
    end
  end

  // serial decoder and pin-level protocol monitor
  logic [7:0] bq [$];
  logic       dq [$];
  int         rd_cnt = 0;
  int         fd_cnt = 0;
  int         proto_err = 0;
  logic [7:0] sh = '0;
  int         bitcnt = 0;
  logic       p_sclk = 1'b0, p_din = 1'b0, p_dc = 1'b0, p_rd = 1'b0;

  always @(negedge clk) begin
    if (lcd_ce_n === 1'b1) begin
      bitcnt = 0;
    end else if (lcd_sclk === 1'b1 && p_sclk === 1'b0) begin
      sh = {sh[6:0], lcd_din};
      bitcnt++;
      if (bitcnt == 8) begin
        bq.push_back(sh);
        dq.push_back(lcd_dc);
        bitcnt = 0;
      end
    end
    if (lcd_sclk === 1'b1 && p_sclk === 1'b1 &&
        (lcd_din !== p_din || lcd_dc !== p_dc))
      proto_err++;
    if (lcd_sclk === 1'b1 && lcd_ce_n === 1'b1)
      proto_err++;
    if (bram_rd_en === 1'b1) begin
      rd_cnt++;
      if (p_rd === 1'b1) proto_err++;
    end
    if (frame_done === 1'b1) fd_cnt++;
    p_sclk = lcd_sclk;
    p_din  = lcd_din;
    p_dc   = lcd_dc;
    p_rd   = bram_rd_en;
  end

  task automatic test_reset();
    logic [14:0] got;
    logic [8:0]  g;
    logic [7:0]  cmd [6];
    int n, rise, bad;
    cmd = '{8'h21, 8'h80 | 8'h31, 8'h04, 8'h14, 8'h20, 8'h0C};
    rst = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    got = {lcd_rst_n, lcd_ce_n, lcd_dc, lcd_sclk, lcd_din,
           bram_rd_en, bram_rd_addr, ready, frame_done};
    n_chk++;
    if (got !== {1'b0, 1'b1, 13'd0})
      $display("FAIL reset_values: got %b want %b", got,
               {1'b0, 1'b1, 13'd0});
    else n_pass++;
    bq.delete();
    dq.delete();
    rst = 1'b0;
    n = 0;
    rise = -1;
    while (n < 2000) begin
      @(posedge clk);
      #1;
      n++;
      start = (n == 100);
      if (rise < 0 && lcd_rst_n === 1'b1) rise = n;
      if (ready === 1'b1) break;
    end
    start = 1'b0;
    n_chk++;
    if (rise != 16)
      $display("FAIL lcd_rst_low: got %0d want 16", rise);
    else n_pass++;
    n_chk++;
    if (n != 440)
      $display("FAIL init_latency: got %0d want 440", n);
    else n_pass++;
    n_chk++;
    if (bq.size() != 6)
      $display("FAIL init_count: got %0d want 6", bq.size());
    else n_pass++;
    for (int i = 0; i < 6; i++) begin
      g = (i < bq.size()) ? {dq[i], bq[i]} : 9'h1FF;
      n_chk++;
      if (g !== {1'b0, cmd[i]})
        $display("FAIL init_cmd%0d: got %h want %h", i, g,
                 {1'b0, cmd[i]});
      else n_pass++;
    end
`ifndef NOKIA_AUTO_REFRESH_EN
    bad = 0;
    repeat (50) begin
      @(posedge clk);
      #1;
      if (ready !== 1'b1 || lcd_ce_n !== 1'b1) bad++;
    end
    n_chk++;
    if (bad != 0 || bq.size() != 6)
      $display("FAIL idle_quiet: got %0d bad/%0d bytes want 0/6",
               bad, bq.size());
    else n_pass++;
`endif
  endtask

  task automatic check_stream(input int nbytes, input string tag);
    logic [8:0] g, w;
    int bad, first;
    for (int i = 0; i < 2; i++) begin
      w = {1'b0, (i == 0) ? 8'h40 : 8'h80};
      g = (i < bq.size()) ? {dq[i], bq[i]} : 9'h1FF;
      n_chk++;
      if (g !== w)
        $display("FAIL %s_hdr%0d: got %h want %h", tag, i, g, w);
      else n_pass++;
    end
    bad = 0;
    first = -1;
    for (int i = 0; i < nbytes; i++) begin
      w = {1'b1, mem[i % 84][8 * (i / 84) +: 8]};
      g = (2 + i < bq.size()) ? {dq[2 + i], bq[2 + i]} : 9'h000;
      if (g !== w) begin
        bad++;
        if (first < 0) first = i;
      end
    end
    n_chk++;
    if (bad != 0)
      $display("FAIL %s_data: got %0d bad bytes (first %0d) want 0",
               tag, bad, first);
    else n_pass++;
  endtask

  task automatic test_frame();
    logic [7:0] c5 [6];
    logic [7:0] xb, g;
    int n, p;
    c5 = '{8'h54, 8'h76, 8'h98, 8'hBA, 8'hDC, 8'hFE};
    rand_dly = 1'b0;
    for (int x = 0; x < 84; x++) begin
      xb = 8'(x);
      mem[x] = {6{xb}};
    end
    mem[5] = 48'hFEDCBA987654;
    bq.delete();
    dq.delete();
    rd_cnt = 0;
    fd_cnt = 0;
    proto_err = 0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n_chk++;
    if (ready !== 1'b0)
      $display("FAIL ready_drop: got %b want 0", ready);
    else n_pass++;
    n = 0;
    while (n < 40000 && frame_done !== 1'b1) begin
      @(posedge clk);
      #1;
      n++;
      start = (n == 10000 || n == 20000);
    end
    start = 1'b0;
    n_chk++;
    if (n != 35416)
      $display("FAIL frame_latency: got %0d want 35416", n);
    else n_pass++;
    @(posedge clk);
    #1;
    n_chk++;
    if ({frame_done, ready} !== 2'b01)
      $display("FAIL done_pulse: got %b want 01", {frame_done, ready});
    else n_pass++;
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if (bq.size() != 506)
      $display("FAIL frame_bytes: got %0d want 506", bq.size());
    else n_pass++;
    check_stream(504, "frame");
    for (int k = 0; k < 6; k++) begin
      p = 2 + 5 + 84 * k;
      g = (p < bq.size()) ? bq[p] : 8'hxx;
      n_chk++;
      if (g !== c5[k])
        $display("FAIL col5_bank%0d: got %h want %h", k, g, c5[k]);
      else n_pass++;
    end
    n_chk++;
    if (rd_cnt != 504)
      $display("FAIL rd_pulses: got %0d want 504", rd_cnt);
    else n_pass++;
    n_chk++;
    if (fd_cnt != 1)
      $display("FAIL done_count: got %0d want 1", fd_cnt);
    else n_pass++;
    n_chk++;
    if (proto_err != 0)
      $display("FAIL protocol: got %0d errors want 0", proto_err);
    else n_pass++;
  endtask

  task automatic test_abort();
    logic [3:0] g;
    int n, k;
    rand_dly = 1'b1;
    for (int x = 0; x < 84; x++)
      mem[x] = {16'($urandom), $urandom};
    bq.delete();
    dq.delete();
    rd_cnt = 0;
    fd_cnt = 0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 0;
    while (rd_cnt < 200 && n < 30000) begin
      @(posedge clk);
      #1;
      n++;
      start = (n == 5000);
    end
    start = 1'b0;
    n_chk++;
    if (rd_cnt != 200)
      $display("FAIL reach_byte200: got %0d want 200", rd_cnt);
    else n_pass++;
    k = int'($urandom_range(40, 2));
    repeat (k) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    g = {lcd_ce_n, lcd_rst_n, lcd_sclk, ready};
    n_chk++;
    if (g !== 4'b1000)
      $display("FAIL abort_pins: got %b want 1000", g);
    else n_pass++;
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if (bq.size() != 201)
      $display("FAIL abort_bytes: got %0d want 201", bq.size());
    else n_pass++;
    check_stream(199, "abort");
  endtask

  task automatic test_no_done();
    n_chk++;
    if (fd_cnt != 0)
      $display("FAIL abort_done: got %0d want 0", fd_cnt);
    else n_pass++;
  endtask

  task automatic test_auto();
    int n, found, t1, t2;
    rand_dly = 1'b0;
    for (int x = 0; x < 84; x++)
      mem[x] = {16'($urandom), $urandom};
    start = 1'b0;
    rd_cnt = 0;
    n = 0;
    found = 0;
    t1 = 0;
    t2 = 0;
    while (n < 80000 && found < 2) begin
      @(posedge clk);
      #1;
      n++;
      if (frame_done === 1'b1) begin
        found++;
        if (found == 1) t1 = n;
        else t2 = n;
      end
    end
    n_chk++;
    if (found != 2)
      $display("FAIL auto_frames: got %0d want 2", found);
    else n_pass++;
    n_chk++;
    if (t1 != 35417)
      $display("FAIL auto_first: got %0d want 35417", t1);
    else n_pass++;
    n_chk++;
    if (t2 - t1 != 35418)
      $display("FAIL auto_period: got %0d want 35418", t2 - t1);
    else n_pass++;
    n_chk++;
    if (rd_cnt != 1008)
      $display("FAIL auto_rd: got %0d want 1008", rd_cnt);
    else n_pass++;
  endtask

  initial begin
    test_reset();
`ifdef NOKIA_AUTO_REFRESH_EN
    test_auto();
`else
    test_frame();
    test_abort();
    test_reset();
    test_no_done();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/nokia_frame_streamer.md
# nokia_frame_streamer

Downstream consumer of the 84×48 frame-buffer BRAM in the Nokia 5110 screen design. Initialises the PCD8544 controller after reset. On request, it then reads the 84 column words (48 bits each) from the BRAM and streams them as 504 display bytes over the write-only 3-wire-plus-DC serial link. It is the only block that drives the LCD pins.

## Interface
- CLK_DIV, 4: half-period of lcd_sclk in clk cycles (≥1).
- RST_CYCLES, 16: cycles lcd_rst_n is held low, then cycles waited after release.
- VOP, 7'h31: contrast value; sent as command 0x80|VOP.

- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  frame refresh request, sampled only when ready=1
- ready  out  1  high in IDLE (init complete, no frame in progress)
- frame_done  out  1  one-cycle pulse after the last data byte
- bram_rd_en  out  1  BRAM read strobe, one-cycle pulse
- bram_rd_addr  out  7  column index 0..83
- bram_data  in  48  column word; bit 0 = top pixel
- bram_valid  in  1  bram_data valid (one cycle after bram_rd_en)
- lcd_rst_n  out  1  PCD8544 reset
- lcd_ce_n  out  1  chip enable
- lcd_dc  out  1  0 = command, 1 = data
- lcd_sclk  out  1  serial clock
- lcd_din  out  1  serial data, MSB first

## Operation
- Reset values: lcd_rst_n=0, lcd_ce_n=1, lcd_dc=0, lcd_sclk=0, lcd_din=0, bram_rd_en=0, bram_rd_addr=0, ready=0, frame_done=0. State = LCD_RST.
- FSM: LCD_RST → LCD_WAIT → INIT → IDLE → HDR → FETCH → WAIT_VALID → SEND → (FETCH | DONE) → IDLE.
- LCD_RST: hold lcd_rst_n=0 for RST_CYCLES cycles, then set it to 1. LCD_WAIT: wait RST_CYCLES cycles.
- INIT: send the commands 0x21, 0x80|VOP, 0x04, 0x14, 0x20, 0x0C in that order, with dc=0. Then enter IDLE with ready=1.
- IDLE: start=1 → HDR, and ready drops the next cycle. start while not ready is ignored, not queued.
- HDR: send command 0x40 (Y=0), then 0x80 (X=0).
- Data order: bank b=0..5 is the outer loop, column x=0..83 the inner loop.
  - FETCH: bram_rd_addr=x and bram_rd_en=1 for one cycle.
  - WAIT_VALID: on bram_valid=1, latch byte bram_data[8b+7:8b]. The block waits indefinitely for bram_valid.
  - SEND: shift the byte out with dc=1.
- Counter wrap: x=83 → x=0, b+1. After b=5, x=83 → DONE. DONE pulses frame_done for one cycle, then IDLE with ready=1.
- Byte transmit, identical for command and data:
  - lcd_ce_n falls, with lcd_dc and bit 7 on lcd_din valid in the same cycle and lcd_sclk=0.
  - Each bit: sclk low for CLK_DIV cycles, then high for CLK_DIV cycles. Next bit is presented on the falling edge.
  - After bit 0's high phase: sclk=0, lcd_ce_n=1 for CLK_DIV cycles (gap).
- rst asserted in any state aborts immediately. All outputs return to reset values next cycle, and the full LCD_RST/INIT sequence reruns.

## Timing
- One byte occupies 17·CLK_DIV cycles: 16·CLK_DIV shifting plus CLK_DIV gap. Each data byte adds 2 cycles of BRAM access (FETCH plus WAIT_VALID).
- Frame latency is counted from the cycle after start is sampled to frame_done=1: 2·17·CLK_DIV + 504·(2+17·CLK_DIV) cycles. With CLK_DIV=4 this is 35416.
- Init latency is counted from rst deassertion to ready=1: 2·RST_CYCLES + 6·17·CLK_DIV cycles. With defaults this is 440.
- Exactly 84·6 = 504 bram_rd_en pulses per frame; never two in consecutive cycles.
- lcd_din and lcd_dc change only while lcd_sclk=0. lcd_sclk toggles only while lcd_ce_n=0.

## Configuration
- NOKIA_AUTO_REFRESH_EN defined:
  - On entering IDLE (after init or after DONE), the FSM moves to HDR on the next cycle without waiting for start.
  - start is ignored, and ready is high only for that single IDLE cycle.
- NOKIA_AUTO_REFRESH_EN undefined: frames are sent only on start, as above.

## Test plan
- Reset release, defaults:
  - lcd_rst_n stays low 16 cycles, then goes high.
  - Decoded SPI command bytes are 0x21, 0xB1, 0x04, 0x14, 0x20, 0x0C, all with dc=0.
  - ready rises 440 cycles after reset release.
- BRAM model where column x = {6{x[7:0]}}, then pulse start:
  - Bytes are 0x40, 0x80 (dc=0), then 504 data bytes (dc=1) repeating 0..83 six times.
  - frame_done pulses exactly 35416 cycles after start.
- Column 5 = 48'hFEDCBA987654, others 0: bytes at positions 5, 89, 173, 257, 341, 425 of the data stream are 0x54, 0x76, 0x98, 0xBA, 0xDC, 0xFE.
- start pulsed mid-frame: no second header and no extra bram_rd_en. Only one frame_done pulse.
- rst asserted during the 200th data byte:
  - Next cycle: lcd_ce_n=1, lcd_rst_n=0.
  - The full init sequence repeats. No frame_done pulse is produced.
- With NOKIA_AUTO_REFRESH_EN and start tied to 0:
  - Frames repeat back-to-back after init.
  - frame_done pulses are 35416+2 cycles apart (DONE cycle plus IDLE cycle).
